csr_wr_arbiter: RTL and testbench

// - Owns the single CSR register-file write port; shares it between the EXU (csrrw/csrrs/csrrc writeback) and the CLINT trap/mret sequencer.
// - Buffers EXU writes in a small FIFO while CLINT holds the port. Drains that FIFO before CLINT is granted, so CLINT reads up-to-date mstatus/mepc/mtvec.
// - Sits between EXU/CLINT and csr_reg. The CLINT waits in its PENDING state until clint_grant_o is asserted.

---
 rtl/csr_wr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_csr_wr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/csr_wr_arbiter.sv
// CSR write-port arbiter: EXU writes (buffered in an in-order FIFO) share the csr_reg port with the CLINT sequencer.
// Optional `CSR_WARB_COALESCE_EN merges an EXU write into the youngest queued entry when the addresses match.
module csr_wr_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_we_i,
  input  logic [ADDR_W-1:0] exu_waddr_i,
  input  logic [DATA_W-1:0] exu_wdata_i,
  output logic              exu_ready_o,
  input  logic              clint_req_i,
  input  logic              clint_busy_i,
  input  logic              clint_we_i,
  input  logic [ADDR_W-1:0] clint_waddr_i,
  input  logic [DATA_W-1:0] clint_wdata_i,
  output logic              clint_grant_o,
  input  logic              flush_i,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              stall_req_o,
  output logic              proto_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic fifo_empty, fifo_full, pop_avail, coal_hit;
  logic exu_ready_c, push, pop, bypass, coal_wr;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;

  assign fifo_empty = (count_q == CNT_W'(0));
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_avail  = ~fifo_empty & (state_q != GRANT);

`ifdef CSR_WARB_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
  assign young_ptr = wr_ptr_q - PTR_W'(1);
  // The youngest entry is off-limits when it is also the head leaving this cycle.
  assign coal_hit  = exu_we_i & ~fifo_empty & (fifo_addr_q[young_ptr] == exu_waddr_i)
                     & ~(pop_avail & (count_q == CNT_W'(1)));
`else
  assign coal_hit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, FIFO control and port ownership.
  always_comb begin
    state_d     = state_q;
    exu_ready_c = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    bypass      = 1'b0;
    coal_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        exu_ready_c = ~fifo_full | pop_avail;
        pop         = pop_avail & ~flush_i;
        if (exu_we_i && exu_ready_c && !flush_i) begin
          if (fifo_empty)    bypass  = 1'b1;
          else if (coal_hit) coal_wr = 1'b1;
          else               push    = 1'b1;
        end
        if (clint_req_i) state_d = (!fifo_empty || exu_we_i) ? DRAIN : GRANT;
      end
      DRAIN: begin
        pop = pop_avail & ~flush_i;
        if (flush_i || count_q <= CNT_W'(1)) state_d = GRANT;
      end
      GRANT: begin
        exu_ready_c = ~fifo_full | coal_hit;
        if (exu_we_i && !flush_i) begin
          if (coal_hit)        coal_wr = 1'b1;
          else if (!fifo_full) push    = 1'b1;
        end
        if (!clint_busy_i && !clint_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single write source per cycle.
  always_comb begin
    issue_we   = 1'b0;
    issue_addr = csr_waddr_o;
    issue_data = csr_wdata_o;
    if (state_q == GRANT) begin
      if (clint_we_i) begin
        issue_we   = 1'b1;
        issue_addr = clint_waddr_i;
        issue_data = clint_wdata_i;
      end
    end else if (pop) begin
      issue_we   = 1'b1;
      issue_addr = fifo_addr_q[rd_ptr_q];
      issue_data = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      issue_we   = 1'b1;
      issue_addr = exu_waddr_i;
      issue_data = exu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= exu_waddr_i;
      fifo_data_q[wr_ptr_q] <= exu_wdata_i;
    end
`ifdef CSR_WARB_COALESCE_EN
    if (coal_wr) fifo_data_q[young_ptr] <= exu_wdata_i;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      proto_err_o <= 1'b0;
    end else begin
      csr_we_o    <= issue_we;
      csr_waddr_o <= issue_addr;
      csr_wdata_o <= issue_data;
      if (clint_we_i && state_q != GRANT) proto_err_o <= 1'b1;
    end
  end

  assign clint_grant_o = (state_q == GRANT);
  assign exu_ready_o   = exu_ready_c;
  assign stall_req_o   = exu_we_i & ~exu_ready_c;

endmodule

// File: tb/tb_csr_wr_arbiter.sv
// Directed bench for csr_wr_arbiter: bypass, drain-before-grant, grant with buffering, flush, protocol error.
module tb_csr_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_we_i, exu_ready_o;
  logic [31:0] exu_waddr_i, exu_wdata_i;
  logic        clint_req_i, clint_busy_i, clint_we_i, clint_grant_o;
  logic [31:0] clint_waddr_i, clint_wdata_i;
  logic        flush_i, csr_we_o, stall_req_o, proto_err_o;
  logic [31:0] csr_waddr_o, csr_wdata_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] e_addr [5] = '{32'h340, 32'h305, 32'h304, 32'h344, 32'h7C0};
  logic [31:0] e_data [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
  logic [31:0] c_addr [3] = '{32'h341, 32'h300, 32'h342};
  logic [31:0] c_data [3] = '{32'h80000200, 32'h1800, 32'h8000000B};

  csr_wr_arbiter #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_we_i(exu_we_i), .exu_waddr_i(exu_waddr_i), .exu_wdata_i(exu_wdata_i),
    .exu_ready_o(exu_ready_o),
    .clint_req_i(clint_req_i), .clint_busy_i(clint_busy_i), .clint_we_i(clint_we_i),
    .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .clint_grant_o(clint_grant_o), .flush_i(flush_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_req_o(stall_req_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_we"}, 64'(csr_we_o), 64'(1));
    check({tag, "_addr"}, 64'(csr_waddr_o), 64'(a));
    check({tag, "_data"}, 64'(csr_wdata_o), 64'(d));
  endtask

  task automatic exu(input logic we, input logic [31:0] a, input logic [31:0] d);
    exu_we_i = we; exu_waddr_i = a; exu_wdata_i = d;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0;
    exu(1'b0, 32'h0, 32'h0);
    clint_req_i = 1'b0; clint_busy_i = 1'b0; clint_we_i = 1'b0;
    clint_waddr_i = '0; clint_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(csr_we_o), 64'(0));
    check("rst_addr", 64'(csr_waddr_o), 64'(0));
    check("rst_data", 64'(csr_wdata_o), 64'(0));
    check("rst_grant", 64'(clint_grant_o), 64'(0));
    check("rst_proto", 64'(proto_err_o), 64'(0));
    check("rst_stall", 64'(stall_req_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Bypass write with an idle port.
    exu(1'b1, 32'h305, 32'h80000100);
    #1 check("byp_ready", 64'(exu_ready_o), 64'(1));
    tick();
    exu(1'b0, 32'h0, 32'h0);
    check_wr("byp", 32'h305, 32'h80000100);
    check("byp_grant", 64'(clint_grant_o), 64'(0));
    tick();
    check("byp_idle_we", 64'(csr_we_o), 64'(0));

    // Empty FIFO and no EXU write: straight to GRANT.
    clint_req_i = 1'b1; clint_busy_i = 1'b1;
    tick();
    check("grant1", 64'(clint_grant_o), 64'(1));

    // CLINT writes while EXU fills the FIFO; fifth EXU write stalls.
    for (int i = 0; i < 5; i++) begin
      exu(1'b1, e_addr[i], e_data[i]);
      if (i < 3) begin
        clint_we_i = 1'b1; clint_waddr_i = c_addr[i]; clint_wdata_i = c_data[i];
      end else begin
        clint_we_i = 1'b0;
      end
      #1;
      if (i < 4) check($sformatf("grant_ready%0d", i), 64'(exu_ready_o), 64'(1));
      else begin
        check("grant_full_ready", 64'(exu_ready_o), 64'(0));
        check("grant_full_stall", 64'(stall_req_o), 64'(1));
        clint_req_i = 1'b0; clint_busy_i = 1'b0;
      end
      tick();
      if (i < 3) check_wr($sformatf("clint%0d", i), c_addr[i], c_data[i]);
      else check($sformatf("grant_nowr%0d", i), 64'(csr_we_o), 64'(0));
    end
    check("rel_grant", 64'(clint_grant_o), 64'(0));

    // IDLE: held fifth write accepted while the head pops; all drain in order.
    #1 check("rel_ready", 64'(exu_ready_o), 64'(1));
    tick();
    exu(1'b0, 32'h0, 32'h0);
    check_wr("drain0", e_addr[0], e_data[0]);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_wr($sformatf("drain%0d", i), e_addr[i], e_data[i]);
    end
    tick();
    check("drain_done", 64'(csr_we_o), 64'(0));

    // Queue two entries in GRANT, release, then re-request: DRAIN precedes GRANT.
    clint_req_i = 1'b1; clint_busy_i = 1'b1;
    tick();
    check("grant2", 64'(clint_grant_o), 64'(1));
    exu(1'b1, 32'h7C1, 32'hA);
    tick();
    exu(1'b1, 32'h7C2, 32'hB);
    tick();
    exu(1'b0, 32'h0, 32'h0);
    check("q2_nowr", 64'(csr_we_o), 64'(0));
    clint_req_i = 1'b0; clint_busy_i = 1'b0;
    tick();
    check("q2_idle", 64'(clint_grant_o), 64'(0));
    clint_req_i = 1'b1; clint_busy_i = 1'b1;
    tick();
    check_wr("dr_pop0", 32'h7C1, 32'hA);
    check("dr_grant0", 64'(clint_grant_o), 64'(0));
    check("dr_ready", 64'(exu_ready_o), 64'(0));
    tick();
    check_wr("dr_pop1", 32'h7C2, 32'hB);
    check("dr_grant1", 64'(clint_grant_o), 64'(1));
    tick();
    check("dr_after", 64'(csr_we_o), 64'(0));

    // Flush three queued entries in GRANT; nothing issues after release.
    for (int i = 0; i < 3; i++) begin
      exu(1'b1, 32'h7C3 + 32'(i), 32'h100 + 32'(i));
      tick();
    end
    exu(1'b0, 32'h0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    clint_req_i = 1'b0; clint_busy_i = 1'b0;
    tick();
    check("fl_idle", 64'(clint_grant_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_nowr%0d", i), 64'(csr_we_o), 64'(0));
    end

    // Same-address writes queued in GRANT.
    clint_req_i = 1'b1; clint_busy_i = 1'b1;
    tick();
    check("grant3", 64'(clint_grant_o), 64'(1));
    exu(1'b1, 32'h300, 32'h8);
    tick();
    exu(1'b1, 32'h300, 32'h88);
    tick();
    exu(1'b0, 32'h0, 32'h0);
    clint_req_i = 1'b0; clint_busy_i = 1'b0;
    tick();
    tick();
`ifdef CSR_WARB_COALESCE_EN
    check_wr("coal0", 32'h300, 32'h88);
    tick();
    check("coal_single", 64'(csr_we_o), 64'(0));
`else
    check_wr("same0", 32'h300, 32'h8);
    tick();
    check_wr("same1", 32'h300, 32'h88);
    tick();
    check("same_done", 64'(csr_we_o), 64'(0));
`endif

    // CLINT write without grant: dropped, sticky error.
    check("pe_before", 64'(proto_err_o), 64'(0));
    clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_wdata_i = 32'hDEAD;
    tick();
    clint_we_i = 1'b0;
    check("pe_nowr", 64'(csr_we_o), 64'(0));
    check("pe_set", 64'(proto_err_o), 64'(1));
    repeat (2) tick();
    check("pe_held", 64'(proto_err_o), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
